// File: rtl/snn_prog_sequencer_if.sv
// Host-to-sequencer word stream: valid/ready handshake carrying one synaptic address and data word.
interface snn_prog_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              host_valid;
  logic              host_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;

  modport master (
    output host_valid,
    output host_addr,
    output host_data,
    input  host_ready
  );

  modport slave (
    input  host_valid,
    input  host_addr,
    input  host_data,
    output host_ready
  );
endinterface

// File: rtl/snn_prog_sequencer.sv
// Programming controller for the snncore write port.
// It streams WTS_CNT synaptic weights, then CONFIG_REG configuration words
// addressed 0..CONFIG_REG-1. It then raises done and pulses run_go for one cycle.
module snn_prog_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WTS_CNT    = 1024,
  parameter int CONFIG_REG = 8,
  parameter int MEM_DEPTH  = 65536,
  parameter int CNT_W      = $clog2(WTS_CNT + CONFIG_REG + 1)
) (
  input  logic                 prgclk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  snn_prog_sequencer_if.slave  i_host,
  output logic                 o_mem_write,
  output logic                 o_cfg_write,
  output logic [ADDR_W-1:0]    o_wr_addr,
  output logic [DATA_W-1:0]    o_wr_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_run_go,
  output logic                 o_seq_err,
  output logic [CNT_W-1:0]     o_prog_cnt
);

  localparam int               CFG_W     = (CONFIG_REG > 1) ? $clog2(CONFIG_REG) : 1;
  localparam logic [CNT_W-1:0] WTS_LAST  = CNT_W'(WTS_CNT - 1);
  localparam logic [CFG_W-1:0] CFG_LAST  = CFG_W'(CONFIG_REG - 1);
  localparam logic [63:0]      MEM_LIMIT = 64'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_WTS,
    S_LOAD_CFG,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_memWrite;
  logic              r_cfgWrite;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [DATA_W-1:0] r_wrData;
  logic              r_busy;
  logic              r_done;
  logic              r_runGo;
  logic              r_seqErr;
  logic [CNT_W-1:0]  r_progCnt;
  logic [CFG_W-1:0]  r_cfgIdx;

  state_t            w_stateNext;
  logic              w_memWriteNext;
  logic              w_cfgWriteNext;
  logic [ADDR_W-1:0] w_wrAddrNext;
  logic [DATA_W-1:0] w_wrDataNext;
  logic              w_doneNext;
  logic              w_runGoNext;
  logic              w_seqErrNext;
  logic [CNT_W-1:0]  w_progCntNext;
  logic [CFG_W-1:0]  w_cfgIdxNext;
  logic              w_hostReady;
  logic              w_accept;
  logic              w_addrLegal;

  assign w_hostReady       = ((r_state == S_LOAD_WTS) || (r_state == S_LOAD_CFG)) && !i_abort;
  assign w_accept          = i_host.host_valid && w_hostReady;
  assign w_addrLegal       = (64'(i_host.host_addr) < MEM_LIMIT);
  assign i_host.host_ready = w_hostReady;

  assign o_mem_write = r_memWrite;
  assign o_cfg_write = r_cfgWrite;
  assign o_wr_addr   = r_wrAddr;
  assign o_wr_data   = r_wrData;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_run_go    = r_runGo;
  assign o_seq_err   = r_seqErr;
  assign o_prog_cnt  = r_progCnt;

  // Next-state and next-output decode: abort dominates, otherwise each phase consumes accepted words.
  always_comb begin
    w_stateNext    = r_state;
    w_memWriteNext = 1'b0;
    w_cfgWriteNext = 1'b0;
    w_runGoNext    = 1'b0;
    w_wrAddrNext   = r_wrAddr;
    w_wrDataNext   = r_wrData;
    w_doneNext     = r_done;
    w_seqErrNext   = r_seqErr;
    w_progCntNext  = r_progCnt;
    w_cfgIdxNext   = r_cfgIdx;

    if (i_abort) begin
      w_stateNext = S_IDLE;
      w_doneNext  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            w_stateNext   = S_LOAD_WTS;
            w_progCntNext = '0;
            w_seqErrNext  = 1'b0;
            w_doneNext    = 1'b0;
            w_cfgIdxNext  = '0;
          end
        end
        S_LOAD_WTS: begin
          if (i_start) begin
            w_seqErrNext = 1'b1;
          end
          if (w_accept) begin
            w_wrAddrNext  = i_host.host_addr;
            w_wrDataNext  = i_host.host_data;
            w_progCntNext = r_progCnt + 1'b1;
            if (w_addrLegal) begin
              w_memWriteNext = 1'b1;
            end else begin
              w_seqErrNext = 1'b1;
            end
            if (r_progCnt == WTS_LAST) begin
              w_stateNext  = S_LOAD_CFG;
              w_cfgIdxNext = '0;
            end
          end
        end
        S_LOAD_CFG: begin
          if (i_start) begin
            w_seqErrNext = 1'b1;
          end
          if (w_accept) begin
            w_cfgWriteNext = 1'b1;
            w_wrAddrNext   = ADDR_W'(r_cfgIdx);
            w_wrDataNext   = i_host.host_data;
            w_progCntNext  = r_progCnt + 1'b1;
            if (r_cfgIdx == CFG_LAST) begin
              w_stateNext = S_DONE;
              w_doneNext  = 1'b1;
              w_runGoNext = 1'b1;
            end else begin
              w_cfgIdxNext = r_cfgIdx + 1'b1;
            end
          end
        end
        default: begin
          w_stateNext = S_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; rst clears everything immediately so a half-done load emits nothing more.
  always_ff @(posedge prgclk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_memWrite <= 1'b0;
      r_cfgWrite <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_runGo    <= 1'b0;
      r_seqErr   <= 1'b0;
      r_progCnt  <= '0;
      r_cfgIdx   <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_memWrite <= w_memWriteNext;
      r_cfgWrite <= w_cfgWriteNext;
      r_wrAddr   <= w_wrAddrNext;
      r_wrData   <= w_wrDataNext;
      r_busy     <= (w_stateNext == S_LOAD_WTS) || (w_stateNext == S_LOAD_CFG);
      r_done     <= w_doneNext;
      r_runGo    <= w_runGoNext;
      r_seqErr   <= w_seqErrNext;
      r_progCnt  <= w_progCntNext;
      r_cfgIdx   <= w_cfgIdxNext;
    end
  end

endmodule

// File: tb/tb_snn_prog_sequencer.sv
// Self-checking bench for snn_prog_sequencer with a word-count based reference model.
module tb_snn_prog_sequencer;

  localparam int W     = 4;
  localparam int C     = 8;
  localparam int MD    = 65536;
  localparam int CNT_W = $clog2(W + C + 1);
  localparam int VW    = 6 + CNT_W + 64;

  logic             prgclk;
  logic             rst;
  logic             start;
  logic             abort;
  logic             memWrite;
  logic             cfgWrite;
  logic [31:0]      wrAddr;
  logic [31:0]      wrData;
  logic             busy;
  logic             done;
  logic             runGo;
  logic             seqErr;
  logic [CNT_W-1:0] progCnt;

  snn_prog_sequencer_if #(.ADDR_W(32), .DATA_W(32)) hostIf ();

  snn_prog_sequencer #(
    .ADDR_W(32), .DATA_W(32), .WTS_CNT(W), .CONFIG_REG(C), .MEM_DEPTH(MD), .CNT_W(CNT_W)
  ) dut (
    .prgclk     (prgclk),
    .rst        (rst),
    .i_start    (start),
    .i_abort    (abort),
    .i_host     (hostIf.slave),
    .o_mem_write(memWrite),
    .o_cfg_write(cfgWrite),
    .o_wr_addr  (wrAddr),
    .o_wr_data  (wrData),
    .o_busy     (busy),
    .o_done     (done),
    .o_run_go   (runGo),
    .o_seq_err  (seqErr),
    .o_prog_cnt (progCnt)
  );

  int errors = 0;
  int checks = 0;
  int memSeen;
  int cfgSeen;

  bit          mLoading;
  bit          mDone;
  bit          mErr;
  bit          mMemWr;
  bit          mCfgWr;
  bit          mRunGo;
  int          mK;
  logic [31:0] mAddr;
  logic [31:0] mData;
  logic        readySeen;
  logic        readyExp;

  initial prgclk = 1'b0;
  always #5 prgclk = ~prgclk;

  function automatic logic [VW-1:0] obsVec();
    return {memWrite, cfgWrite, runGo, done, busy, seqErr, progCnt, wrAddr, wrData};
  endfunction

  function automatic logic [VW-1:0] expVec();
    return {mMemWr, mCfgWr, mRunGo, mDone, mLoading, mErr, CNT_W'(mK), mAddr, mData};
  endfunction

  task automatic modelReset();
    mLoading = 0; mDone = 0; mErr = 0; mMemWr = 0; mCfgWr = 0; mRunGo = 0;
    mK = 0; mAddr = '0; mData = '0;
  endtask

  // One clock of the load protocol expressed as "k words accepted out of W+C".
  task automatic modelAdvance(input logic s, input logic a, input logic v,
                              input logic [31:0] ad, input logic [31:0] d);
    mMemWr = 0; mCfgWr = 0; mRunGo = 0;
    if (a) begin
      mLoading = 0;
      mDone    = 0;
    end else if (mLoading) begin
      if (s) mErr = 1;
      if (v) begin
        if (mK < W) begin
          mAddr = ad;
          mData = d;
          if (ad < MD) mMemWr = 1;
          else         mErr   = 1;
        end else begin
          mCfgWr = 1;
          mAddr  = 32'(mK - W);
          mData  = d;
        end
        mK++;
        if (mK == W + C) begin
          mLoading = 0;
          mDone    = 1;
          mRunGo   = 1;
        end
      end
    end else if (s) begin
      mLoading = 1;
      mK       = 0;
      mErr     = 0;
      mDone    = 0;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic v,
                               input logic [31:0] ad, input logic [31:0] d);
    @(negedge prgclk);
    start = s; abort = a;
    hostIf.host_valid = v; hostIf.host_addr = ad; hostIf.host_data = d;
    #1;
    readySeen = hostIf.host_ready;
    readyExp  = mLoading && !a;
    modelAdvance(s, a, v, ad, d);
    @(posedge prgclk);
    #1;
    if (memWrite === 1'b1) memSeen++;
    if (cfgWrite === 1'b1) cfgSeen++;
  endtask

  task automatic driveLoad(input string tag, input int pctValid, input int badIdx, input int cfgStartIdx);
    int budget = 0;
    logic v;
    logic s;
    logic [31:0] ad;
    while (mLoading && budget < 400) begin
      v  = (int'($urandom_range(99)) < pctValid);
      ad = (mK == badIdx && mK < W) ? 32'(MD) : 32'($urandom_range(MD - 1));
      s  = (cfgStartIdx >= 0) && (mK == W + cfgStartIdx);
      applyStimulus(s, 1'b0, v, ad, $urandom);
      checks++;
      if (readySeen !== readyExp) begin
        errors++;
        $display("[TB] FAIL %s_ready: got %b want %b at word %0d", tag, readySeen, readyExp, mK);
      end
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL %s_cycle: got %h want %h at word %0d", tag, obsVec(), expVec(), mK);
      end
      budget++;
    end
    checks++;
    if (mLoading) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d words want %0d", tag, mK, W + C);
    end
  endtask

  task automatic startLoad(input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    checks++;
    if (obsVec() !== expVec()) begin
      errors++;
      $display("[TB] FAIL %s_start: got %h want %h", tag, obsVec(), expVec());
    end
  endtask

  task automatic test_reset();
    start = 0; abort = 0;
    hostIf.host_valid = 0; hostIf.host_addr = '0; hostIf.host_data = '0;
    rst = 1;
    modelReset();
    repeat (2) @(posedge prgclk);
    #1;
    checks++;
    if (obsVec() !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h want 0", obsVec());
    end
    checks++;
    if (hostIf.host_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b want 0", hostIf.host_ready);
    end
    @(negedge prgclk);
    rst = 0;
  endtask

  task automatic test_full_load();
    memSeen = 0; cfgSeen = 0;
    startLoad("full");
    driveLoad("full", 100, -1, -1);
    checks++;
    if (done !== 1'b1 || progCnt !== CNT_W'(W + C) || seqErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_final: got done=%b cnt=%0d err=%b want 1 %0d 0", done, progCnt, seqErr, W + C);
    end
    checks++;
    if (memSeen != W || cfgSeen != C) begin
      errors++;
      $display("[TB] FAIL full_strobes: got mem=%0d cfg=%0d want %0d %0d", memSeen, cfgSeen, W, C);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
    checks++;
    if (obsVec() !== expVec()) begin
      errors++;
      $display("[TB] FAIL full_hold: got %h want %h", obsVec(), expVec());
    end
  endtask

  task automatic test_stall();
    memSeen = 0; cfgSeen = 0;
    startLoad("stall");
    driveLoad("stall", 50, -1, -1);
    checks++;
    if (memSeen + cfgSeen != W + C || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_total: got writes=%0d done=%b want %0d 1", memSeen + cfgSeen, done, W + C);
    end
  endtask

  task automatic test_bad_addr();
    memSeen = 0; cfgSeen = 0;
    startLoad("badaddr");
    driveLoad("badaddr", 100, int'($urandom_range(W - 1)), -1);
    checks++;
    if (seqErr !== 1'b1 || done !== 1'b1 || progCnt !== CNT_W'(W + C) || memSeen != W - 1) begin
      errors++;
      $display("[TB] FAIL badaddr_final: got err=%b done=%b cnt=%0d mem=%0d want 1 1 %0d %0d",
               seqErr, done, progCnt, memSeen, W + C, W - 1);
    end
  endtask

  task automatic test_abort();
    memSeen = 0; cfgSeen = 0;
    startLoad("abort");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'($urandom_range(MD - 1)), $urandom);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL abort_pre: got %h want %h", obsVec(), expVec());
      end
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h10, 32'hdead);
    checks++;
    if (readySeen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_ready: got %b want 0", readySeen);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL abort_idle: got %h want %h", obsVec(), expVec());
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 32'hbeef);
    end
    checks++;
    if (progCnt !== CNT_W'(2) || done !== 1'b0 || memSeen != 2) begin
      errors++;
      $display("[TB] FAIL abort_hold: got cnt=%0d done=%b mem=%0d want 2 0 2", progCnt, done, memSeen);
    end
    startLoad("reload");
    driveLoad("reload", 100, -1, -1);
    checks++;
    if (progCnt !== CNT_W'(W + C) || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reload_final: got cnt=%0d done=%b want %0d 1", progCnt, done, W + C);
    end
  endtask

  task automatic test_start_busy();
    startLoad("busystart");
    driveLoad("busystart", 100, -1, 3);
    checks++;
    if (seqErr !== 1'b1 || done !== 1'b1 || progCnt !== CNT_W'(W + C)) begin
      errors++;
      $display("[TB] FAIL busystart_final: got err=%b done=%b cnt=%0d want 1 1 %0d", seqErr, done, progCnt, W + C);
    end
    startLoad("back_to_back");
    checks++;
    if (done !== 1'b0 || seqErr !== 1'b0 || busy !== 1'b1 || progCnt !== '0) begin
      errors++;
      $display("[TB] FAIL back_to_back_restart: got done=%b err=%b busy=%b cnt=%0d want 0 0 1 0",
               done, seqErr, busy, progCnt);
    end
    driveLoad("back_to_back", 75, -1, -1);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL back_to_back_done: got %b want 1", done);
    end
  endtask

  task automatic test_async_reset();
    startLoad("asyncrst");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h123, 32'hcafe);
    checks++;
    if (memWrite !== 1'b1) begin
      errors++;
      $display("[TB] FAIL asyncrst_pre: got mem_write=%b want 1", memWrite);
    end
    #2;
    rst = 1;
    #1;
    modelReset();
    checks++;
    if (obsVec() !== '0) begin
      errors++;
      $display("[TB] FAIL asyncrst_outputs: got %h want 0", obsVec());
    end
    checks++;
    if (hostIf.host_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL asyncrst_ready: got %b want 0", hostIf.host_ready);
    end
    @(negedge prgclk);
    rst = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h55, 32'h66);
    checks++;
    if (obsVec() !== expVec()) begin
      errors++;
      $display("[TB] FAIL asyncrst_after: got %h want %h", obsVec(), expVec());
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_bad_addr();
    test_abort();
    test_start_busy();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
